// File: rtl/uart_rx.sv
// UART receiver: start/8 data (LSB first)/optional parity/stop, PRESCALE clocks per bit.
// Define RX_MAJORITY_VOTE_EN to decide each bit by a 3-sample majority vote around mid-bit.
module uart_rx #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a 0 on RX_IN
  // S_START  | inside start bit, glitch check at the decision count
  // S_DATA   | shifting in DATA_WIDTH data bits
  // S_PARITY | checking the parity bit
  // S_STOP   | stop bit decision, frame evaluated, then back to idle
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] DATA_BITS = BW'(DATA_WIDTH);

  state_t                  state_q, state_d;
  logic [CW-1:0]           edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    par_ok_q, par_ok_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;
  logic                    rx_bit;
  logic                    decide;
  logic                    wrap;

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] DECIDE_CNT = CW'(PRESCALE / 2 + 1);
  logic smp0_q, smp0_d, smp1_q, smp1_d;

  always_comb begin
    smp0_d = smp0_q;
    smp1_d = smp1_q;
    if (edge_cnt_q == CW'(PRESCALE / 2 - 1)) smp0_d = RX_IN;
    if (edge_cnt_q == CW'(PRESCALE / 2))     smp1_d = RX_IN;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      smp0_q <= 1'b0;
      smp1_q <= 1'b0;
    end else begin
      smp0_q <= smp0_d;
      smp1_q <= smp1_d;
    end
  end

  // The third sample is the live line value, so the vote resolves in the decision cycle.
  assign rx_bit = (smp0_q & smp1_q) | (smp0_q & RX_IN) | (smp1_q & RX_IN);
`else
  localparam logic [CW-1:0] DECIDE_CNT = CW'(PRESCALE / 2);
  assign rx_bit = RX_IN;
`endif

  assign decide = (edge_cnt_q == DECIDE_CNT);
  assign wrap   = (edge_cnt_q == LAST_CNT);

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_ok_d     = par_ok_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!RX_IN) begin
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_ok_d  = 1'b1;
          shift_d   = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (decide && rx_bit) state_d = S_IDLE;
        else if (wrap)        state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          shift_d   = {rx_bit, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
        if (wrap && bit_cnt_d == DATA_BITS) state_d = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (decide) par_ok_d = (rx_bit == (^shift_q ^ par_typ_q));
        if (wrap)   state_d  = S_STOP;
      end
      S_STOP: begin
        // Decide at mid stop bit and leave at once so a back-to-back start is not missed.
        if (decide) begin
          state_d   = S_IDLE;
          stp_err_d = ~rx_bit;
          par_err_d = ~par_ok_q;
          if (rx_bit && par_ok_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE || state_d == S_IDLE || wrap) edge_cnt_d = '0;
    else                                                 edge_cnt_d = edge_cnt_q + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_ok_q     <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_ok_q     <= par_ok_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_uart_rx;
  localparam int PRESCALE = 8;
`ifdef RX_MAJORITY_VOTE_EN
  localparam int ADJ = 1;
`else
  localparam int ADJ = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       par_err;
  logic       stp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int dv_cnt, pe_cnt, se_cnt, pe_cyc, se_cyc;
  int dv_cyc[4];
  logic [7:0] dv_dat[4];

  uart_rx #(.PRESCALE(PRESCALE), .DATA_WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA),
    .Data_Valid(Data_Valid),
    .par_err(par_err),
    .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  // Rising edge n sets cyc = n; a pulse seen after edge n is logged at cycle n.
  always @(posedge CLK) begin
    cyc = cyc + 1;
    #1;
    if (Data_Valid) begin
      if (dv_cnt < 4) begin
        dv_cyc[dv_cnt] = cyc;
        dv_dat[dv_cnt] = P_DATA;
      end
      dv_cnt = dv_cnt + 1;
    end
    if (par_err) begin
      pe_cnt = pe_cnt + 1;
      pe_cyc = cyc;
    end
    if (stp_err) begin
      se_cnt = se_cnt + 1;
      se_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    dv_cnt = 0;
    pe_cnt = 0;
    se_cnt = 0;
    pe_cyc = -1;
    se_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      dv_cyc[i] = -1;
      dv_dat[i] = 8'h00;
    end
  endtask

  task automatic send_bit(input logic b);
    RX_IN = b;
    repeat (PRESCALE) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // flip toggles PAR_EN/PAR_TYP right after the start bit to prove they were latched.
  task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                            input logic stop_bit, input logic flip);
    t0 = cyc;
    send_bit(1'b0);
    if (flip) begin
      PAR_EN  = ~PAR_EN;
      PAR_TYP = ~PAR_TYP;
    end
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par_on) send_bit(par_bit);
    send_bit(stop_bit);
  endtask

  initial begin
    clear_log();
    RST     = 1'b0;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_p_data", int'(P_DATA), 0);
    chk("reset_dv", int'(Data_Valid), 0);
    chk("reset_par_err", int'(par_err), 0);
    chk("reset_stp_err", int'(stp_err), 0);
    RST = 1'b1;
    idle(4);

    // 0xA5, no parity; PAR_EN/PAR_TYP flipped mid-frame must be ignored
    clear_log();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(10);
    chk("a5_dv_count", dv_cnt, 1);
    chk("a5_latency", dv_cyc[0] - t0, 78 + ADJ);
    chk("a5_data", int'(dv_dat[0]), 'hA5);
    chk("a5_par_err", pe_cnt, 0);
    chk("a5_stp_err", se_cnt, 0);

    // 0x3C even parity, correct parity bit 0
    clear_log();
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("3c_dv_count", dv_cnt, 1);
    chk("3c_latency", dv_cyc[0] - t0, 86 + ADJ);
    chk("3c_data", int'(dv_dat[0]), 'h3C);
    chk("3c_par_err", pe_cnt, 0);

    // 0x3C even parity, wrong parity bit 1; P_DATA keeps 0x3C only because it held
    clear_log();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);
    chk("3c_bad_dv_count", dv_cnt, 0);
    chk("3c_bad_par_err", pe_cnt, 1);
    chk("3c_bad_par_cyc", pe_cyc - t0, 86 + ADJ);
    chk("3c_bad_stp_err", se_cnt, 0);
    chk("3c_bad_p_data", int'(P_DATA), 'h3C);

    // 0x07 odd parity: three ones, so the odd parity bit is 0
    clear_log();
    PAR_TYP = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("07_odd_dv_count", dv_cnt, 1);
    chk("07_odd_data", int'(dv_dat[0]), 'h07);
    chk("07_odd_par_err", pe_cnt, 0);

    // 0x81, no parity, stop bit 0
    clear_log();
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(30);
    chk("81_stp_count", se_cnt, 1);
    chk("81_stp_cyc", se_cyc - t0, 78 + ADJ);
    chk("81_dv_count", dv_cnt, 0);
    chk("81_par_err", pe_cnt, 0);
    chk("81_p_data_held", int'(P_DATA), 'h07);

    // two-cycle start glitch, then a clean 0x55
    clear_log();
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    idle(20);
    chk("glitch_dv", dv_cnt, 0);
    chk("glitch_par_err", pe_cnt, 0);
    chk("glitch_stp_err", se_cnt, 0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("55_dv_count", dv_cnt, 1);
    chk("55_latency", dv_cyc[0] - t0, 78 + ADJ);
    chk("55_data", int'(dv_dat[0]), 'h55);

    // back-to-back 0x01 then 0xFE
    clear_log();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    chk("b2b_dv_count", dv_cnt, 2);
    chk("b2b_first", int'(dv_dat[0]), 'h01);
    chk("b2b_second", int'(dv_dat[1]), 'hFE);
    chk("b2b_spacing", dv_cyc[1] - dv_cyc[0], 80);
    chk("b2b_stp_err", se_cnt, 0);

    // reset pulse at cycle 40 of a frame, then line idle
    clear_log();
    t0 = cyc;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    RX_IN = 1'b1;
    RST   = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    idle(100);
    chk("rst_p_data", int'(P_DATA), 0);
    chk("rst_dv", int'(Data_Valid), 0);
    chk("rst_par_err", int'(par_err), 0);
    chk("rst_stp_err", int'(stp_err), 0);
    chk("rst_pulses", dv_cnt + pe_cnt + se_cnt, 0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("77_dv_count", dv_cnt, 1);
    chk("77_latency", dv_cyc[0] - t0, 78 + ADJ);
    chk("77_data", int'(P_DATA), 'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
